// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: folded SubBytes engine shared by the round datapath
// (128-bit state) and the key schedule (32-bit SubWord). A bank of LANES
// sbox lookups is stepped over the job's bytes, one pass per cycle, and the
// result is returned on a single valid/ready port tagged with its source.
// Optional macro SUBBYTES_SCHED_STATS_EN adds per-source handshake counters
// (st_count_o, kw_count_o).
//
// state | meaning
// IDLE  | readies driven from the valids; an accept latches operand and source
// BUSY  | one pass of LANES sbox lookups per cycle into the result register
// DONE  | result held on the output port until out_ready_i
module sub_bytes_sched #(
  parameter int LANES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         st_valid_i,
  output logic         st_ready_o,
  input  logic [127:0] st_in_i,
  input  logic         kw_valid_i,
  output logic         kw_ready_o,
  input  logic [31:0]  kw_in_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_data_o,
  output logic         out_src_o
`ifdef SUBBYTES_SCHED_STATS_EN
  ,
  output logic [15:0]  st_count_o,
  output logic [15:0]  kw_count_o
`endif
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_sched: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam int N_ST = 16 / LANES;
  localparam int N_KW = (LANES >= 4) ? 1 : 4 / LANES;
  localparam logic [3:0] LAST_ST = 4'(N_ST - 1);
  localparam logic [3:0] LAST_KW = 4'(N_KW - 1);

  // AES forward sbox, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state_q;
  logic [3:0]   pass_q;
  logic         last_src_q;
  logic         src_q;
  logic [127:0] op_q;
  logic [127:0] res_q;
  logic [127:0] res_d;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic         out_src_q;

  logic st_acc;
  logic kw_acc;
  logic pass_last;
  int   base;
  int   idx;
  logic [6:0] lo;

  // Round-robin grant: on a conflict the source not served last wins.
  assign st_ready_o = (state_q == IDLE) && (!kw_valid_i || last_src_q);
  assign kw_ready_o = (state_q == IDLE) && (!st_valid_i || !last_src_q);
  assign st_acc     = st_valid_i && st_ready_o;
  assign kw_acc     = kw_valid_i && kw_ready_o;
  assign pass_last  = (pass_q == (src_q ? LAST_KW : LAST_ST));

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;

  // One pass of the sbox bank; key words sit in bytes 12..15 so lanes past byte 15 idle.
  always_comb begin
    res_d = res_q;
    base  = src_q ? 12 : 0;
    idx   = 0;
    lo    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx = base + int'(pass_q) * LANES + l;
      if (idx < 16) begin
        lo = 7'((15 - idx) * 8);
        res_d[lo +: 8] = sbox(op_q[lo +: 8]);
      end
    end
  end

  // Job sequencer: accept, step passes, hold result until the consumer takes it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      pass_q      <= '0;
      last_src_q  <= 1'b1;
      src_q       <= 1'b0;
      op_q        <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (st_acc || kw_acc) begin
            op_q       <= kw_acc ? {96'h0, kw_in_i} : st_in_i;
            src_q      <= kw_acc;
            last_src_q <= kw_acc;
            res_q      <= '0;
            pass_q     <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          res_q  <= res_d;
          pass_q <= pass_q + 4'd1;
          if (pass_last) begin
            out_data_q  <= res_d;
            out_src_q   <= src_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SUBBYTES_SCHED_STATS_EN
  logic [15:0] st_cnt_q;
  logic [15:0] kw_cnt_q;

  assign st_count_o = st_cnt_q;
  assign kw_count_o = kw_cnt_q;

  // Count completed output handshakes per source, saturating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_cnt_q <= '0;
      kw_cnt_q <= '0;
    end else if (out_valid_q && out_ready_i) begin
      if (out_src_q) begin
        if (kw_cnt_q != 16'hFFFF) kw_cnt_q <= kw_cnt_q + 16'd1;
      end else begin
        if (st_cnt_q != 16'hFFFF) st_cnt_q <= st_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Directed bench for sub_bytes_sched with an expected-result queue and an
// arithmetic (GF(2^8) inverse + affine) sbox model.
module tb_sub_bytes_sched;

  localparam int LANES = 4;
  localparam int N_ST  = 16 / LANES;
  localparam int N_KW  = (LANES >= 4) ? 1 : 4 / LANES;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [127:0] st_in = '0;
  logic         kw_valid = 1'b0;
  logic         kw_ready;
  logic [31:0]  kw_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_src;
`ifdef SUBBYTES_SCHED_STATS_EN
  logic [15:0]  st_count;
  logic [15:0]  kw_count;
`endif

  int checks   = 0;
  int failures = 0;
  int hs_st    = 0;
  int hs_kw    = 0;

  typedef struct {
    logic [127:0] data;
    logic         src;
  } exp_t;
  exp_t sb_q[$];

  sub_bytes_sched #(.LANES(LANES)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .st_valid_i (st_valid),
    .st_ready_o (st_ready),
    .st_in_i    (st_in),
    .kw_valid_i (kw_valid),
    .kw_ready_o (kw_ready),
    .kw_in_i    (kw_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_src_o  (out_src)
`ifdef SUBBYTES_SCHED_STATS_EN
    ,
    .st_count_o (st_count),
    .kw_count_o (kw_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic src, input logic [127:0] op);
    logic [127:0] r;
    r = '0;
    if (src) begin
      for (int i = 0; i < 4; i++) r[31-8*i -: 8] = sbox_m(op[31-8*i -: 8]);
    end else begin
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_m(op[127-8*i -: 8]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: request, accept, latency, optional backpressure, output handshake.
  task automatic job(input logic src, input logic [127:0] op, input logic [127:0] exp,
                     input bit drop, input bit conflict, input int bp);
    bit ok;
    bit stable;
    int lat;
    logic [127:0] hold;
    exp_t e;
    @(negedge clk);
    if (src) begin kw_in = op[31:0]; kw_valid = 1'b1; end
    else     begin st_in = op;       st_valid = 1'b1; end
    out_ready = (bp == 0);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (src ? kw_ready : st_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("accept", 128'(ok), 128'(1));
    if (!ok) begin st_valid = 1'b0; kw_valid = 1'b0; return; end
    if (conflict) check("grant", 128'({st_ready, kw_ready}), 128'(src ? 2'b01 : 2'b10));
    @(posedge clk);
    sb_q.push_back('{exp, src});
    #1;
    if (drop) begin
      if (src) kw_valid = 1'b0; else st_valid = 1'b0;
    end
    check("busy_ready", 128'({st_ready, kw_ready}), 128'(0));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
    check("latency", 128'(lat), 128'(src ? N_KW : N_ST));
    e = sb_q.pop_front();
    if (lat == 0) return;
    hold = out_data;
    stable = 1'b1;
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      if (!out_valid || out_data !== hold || out_src !== src || st_ready || kw_ready) stable = 1'b0;
    end
    if (bp > 0) check("bp_stable", 128'(stable), 128'(1));
    out_ready = 1'b1;
    check("data", out_data, e.data);
    check("src", 128'(out_src), 128'(e.src));
    @(posedge clk); #1;
    if (src) hs_kw++; else hs_st++;
    check("hs_done", 128'(out_valid), 128'(0));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] r;
    // reset
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_data", out_data, 128'(0));
    check("rst_src", 128'(out_src), 128'(0));
    check("rst_st_ready", 128'(st_ready), 128'(1));

    // conflict from reset: state first, then alternating; first two use the reference vectors
    st_in = 128'h193de3bea0f4e22b9ac68d2ae9f84808; st_valid = 1'b1;
    kw_in = 32'hcf4f3c09; kw_valid = 1'b1;
    @(negedge clk) rst = 1'b0;
    job(1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b1, 0);
    r = {$urandom, $urandom, $urandom, $urandom};
    st_in = r;
    job(1'b1, {96'h0, 32'hcf4f3c09}, {96'h0, 32'h8a84eb01}, 1'b0, 1'b1, 0);
    kw_in = 32'h09cf4f3c;
    job(1'b0, r, model(1'b0, r), 1'b0, 1'b1, 0);
    st_in = ~r;
    job(1'b1, {96'h0, 32'h09cf4f3c}, model(1'b1, {96'h0, 32'h09cf4f3c}), 1'b1, 1'b1, 0);
    st_valid = 1'b0;

    // backpressure on both sources
    r = {$urandom, $urandom, $urandom, $urandom};
    job(1'b0, r, model(1'b0, r), 1'b1, 1'b0, 10);
    r = {96'h0, $urandom};
    job(1'b1, r, model(1'b1, r), 1'b1, 1'b0, 3);

    // assorted single-requester jobs
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      if (i[0]) r[127:32] = '0;
      job(i[0], r, model(i[0], r), 1'b1, 1'b0, 0);
    end

    // async reset during the second busy cycle of a state job
    @(negedge clk);
    st_in = {$urandom, $urandom, $urandom, $urandom}; st_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 st_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_data", out_data, 128'(0));
    @(negedge clk) rst = 1'b0;
    out_ready = 1'b0;
    r = {$urandom, $urandom, $urandom, $urandom};
    job(1'b0, r, model(1'b0, r), 1'b1, 1'b0, 0);
    r = {96'h0, $urandom};
    job(1'b1, r, model(1'b1, r), 1'b1, 1'b0, 0);

`ifdef SUBBYTES_SCHED_STATS_EN
    check("st_count", 128'(st_count), 128'(1));
    check("kw_count", 128'(kw_count), 128'(1));
`endif
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
